// File: rtl/pattern_write_arbiter.sv
// Purpose : arbitrates host bulk loads and single-field core writes onto one pattern buffer write port.
// Latency : every accepted write appears on the write port 1 cycle after acceptance.
// Backpres: the core is never stalled; the host is held off (host_ready=0) in any cycle the core requests.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   host_start/host_buf             begin a bulk load of buffer host_buf (ignored while loading)
//   host_valid/host_data/host_ready host field stream, one field per transfer
//   core_req/core_buf/core_field/core_data/core_ack   single-field core write, always acked
//   core_err                        pulse: the core write one cycle earlier had an out-of-range field
//   load_busy/load_done             bulk load in progress / last field of a load written
//   bufp_out/fieldwp_out/field_out/field_write_out    registered pattern buffer write port
module pattern_write_arbiter #(
    parameter int BUFFER_SIZE  = 22,
    parameter int BUFFER_WIDTH = 6,
    parameter int NO_BUFS      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_start,
    input  logic [2:0]              host_buf,
    input  logic                    host_valid,
    input  logic [BUFFER_WIDTH-1:0] host_data,
    output logic                    host_ready,
    input  logic                    core_req,
    input  logic [2:0]              core_buf,
    input  logic [4:0]              core_field,
    input  logic [BUFFER_WIDTH-1:0] core_data,
    output logic                    core_ack,
    output logic                    core_err,
    output logic                    load_busy,
    output logic                    load_done,
    output logic [2:0]              bufp_out,
    output logic [4:0]              fieldwp_out,
    output logic [BUFFER_WIDTH-1:0] field_out,
    output logic                    field_write_out
);

    // Buffer indices are carried on fixed 3-bit buses.
    if (NO_BUFS < 1 || NO_BUFS > 8) begin : g_bad_no_bufs
        $error("NO_BUFS must fit a 3-bit buffer index");
    end

    localparam logic [4:0] LAST_FIELD = 5'(BUFFER_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  fcnt;
    logic [2:0]  lbuf;
    logic        host_xfer;
    logic        core_wr;

    // Reset is folded in so the host never sees a ready while a reset is pending.
    assign host_ready = (state == LOAD) && !core_req && !reset;
    assign core_ack   = core_req;
    assign host_xfer  = host_valid && host_ready;
    // Out-of-range core writes are acked but dropped.
    assign core_wr    = core_req && (core_field <= LAST_FIELD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            fcnt            <= 5'd0;
            lbuf            <= 3'd0;
            load_busy       <= 1'b0;
            load_done       <= 1'b0;
            core_err        <= 1'b0;
            field_write_out <= 1'b0;
            bufp_out        <= 3'd0;
            fieldwp_out     <= 5'd0;
            field_out       <= '0;
        end else begin
            field_write_out <= 1'b0;
            load_done       <= 1'b0;
            core_err        <= core_req && (core_field > LAST_FIELD);

            // Write port: core wins; host_xfer is already excluded whenever core_req is high.
            if (core_wr) begin
                field_write_out <= 1'b1;
                bufp_out        <= core_buf;
                fieldwp_out     <= core_field;
                field_out       <= core_data;
            end else if (host_xfer) begin
                field_write_out <= 1'b1;
                bufp_out        <= lbuf;
                fieldwp_out     <= fcnt;
                field_out       <= host_data;
            end

            case (state)
                IDLE: begin
                    if (host_start) begin
                        lbuf      <= host_buf;
                        fcnt      <= 5'd0;
                        state     <= LOAD;
                        load_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    // host_start is deliberately ignored here.
                    if (host_xfer) begin
                        if (fcnt == LAST_FIELD) begin
                            fcnt      <= 5'd0;
                            state     <= IDLE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            fcnt <= fcnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_write_arbiter.sv
module tb_pattern_write_arbiter;

    localparam int SIZE = 22;
    localparam int W    = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         host_start;
    logic [2:0]   host_buf;
    logic         host_valid;
    logic [W-1:0] host_data;
    logic         host_ready;
    logic         core_req;
    logic [2:0]   core_buf;
    logic [4:0]   core_field;
    logic [W-1:0] core_data;
    logic         core_ack;
    logic         core_err;
    logic         load_busy;
    logic         load_done;
    logic [2:0]   bufp_out;
    logic [4:0]   fieldwp_out;
    logic [W-1:0] field_out;
    logic         field_write_out;

    always #5 clk = ~clk;

    pattern_write_arbiter #(.BUFFER_SIZE(SIZE), .BUFFER_WIDTH(W), .NO_BUFS(8)) dut (
        .clk(clk), .reset(reset),
        .host_start(host_start), .host_buf(host_buf), .host_valid(host_valid),
        .host_data(host_data), .host_ready(host_ready),
        .core_req(core_req), .core_buf(core_buf), .core_field(core_field),
        .core_data(core_data), .core_ack(core_ack), .core_err(core_err),
        .load_busy(load_busy), .load_done(load_done),
        .bufp_out(bufp_out), .fieldwp_out(fieldwp_out), .field_out(field_out),
        .field_write_out(field_write_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a load is "which buffer, how many fields still owed".
    bit m_loading = 0;
    int m_buf     = 0;
    int m_left    = 0;
    // Expected write-port contents after the next edge (held between writes).
    int e_fw = 0, e_ld = 0, e_err = 0, e_busy = 0;
    int e_buf = 0, e_field = 0, e_data = 0;
    // Observed event counters for scenario-level checks.
    int n_str = 0, n_done = 0, n_b3 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        reset      = 1'b0;
        host_start = 1'b0;
        host_valid = 1'b0;
        core_req   = 1'b0;
    endtask

    // Inputs are already applied; check combinational outputs, advance one edge, check registered outputs.
    task automatic cycle();
        bit exp_ready, xfer;
        #1;
        exp_ready = !reset && m_loading && !core_req;
        check("host_ready", {31'd0, host_ready}, {31'd0, exp_ready});
        check("core_ack", {31'd0, core_ack}, {31'd0, core_req});
        xfer = host_valid && exp_ready;
        if (reset) begin
            e_fw = 0; e_ld = 0; e_err = 0;
            e_buf = 0; e_field = 0; e_data = 0;
            m_loading = 0; m_buf = 0; m_left = 0;
        end else begin
            e_fw  = 0;
            e_ld  = 0;
            e_err = (core_req && int'(core_field) >= SIZE) ? 1 : 0;
            if (core_req && int'(core_field) < SIZE) begin
                e_fw = 1; e_buf = core_buf; e_field = core_field; e_data = core_data;
            end else if (xfer) begin
                e_fw = 1; e_buf = m_buf; e_field = SIZE - m_left; e_data = host_data;
            end
            if (!m_loading) begin
                if (host_start) begin
                    m_loading = 1; m_buf = host_buf; m_left = SIZE;
                end
            end else if (xfer) begin
                m_left--;
                if (m_left == 0) begin
                    m_loading = 0;
                    e_ld = 1;
                end
            end
        end
        e_busy = m_loading ? 1 : 0;
        @(posedge clk);
        #1;
        check("field_write_out", {31'd0, field_write_out}, e_fw);
        check("load_done", {31'd0, load_done}, e_ld);
        check("core_err", {31'd0, core_err}, e_err);
        check("load_busy", {31'd0, load_busy}, e_busy);
        check("bufp_out", {29'd0, bufp_out}, e_buf);
        check("fieldwp_out", {27'd0, fieldwp_out}, e_field);
        check("field_out", {26'd0, field_out}, e_data);
        if (field_write_out) n_str++;
        if (load_done) n_done++;
        if (field_write_out && bufp_out == 3'd3) n_b3++;
    endtask

    task automatic start_load(input int b);
        host_start = 1'b1;
        host_buf   = 3'(b);
        host_valid = 1'b0;
        cycle();
        host_start = 1'b0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            host_valid = 1'b1;
            host_data  = W'(base + i);
            cycle();
        end
        host_valid = 1'b0;
    endtask

    initial begin
        set_idle();
        host_buf = 3'd0; host_data = '0;
        core_buf = 3'd0; core_field = 5'd0; core_data = '0;

        // Reset, including a core request that must be acked but not written.
        reset = 1'b1;
        cycle();
        core_req = 1'b1; core_field = 5'd3; core_buf = 3'd4; core_data = 6'h15;
        cycle();
        core_req = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();

        // Bulk load of buffer 5 with data equal to the field index.
        n_str = 0; n_done = 0;
        start_load(5);
        for (int i = 0; i < SIZE; i++) begin
            host_valid = 1'b1;
            host_data  = W'(i);
            cycle();
            check("bulk_field", {27'd0, fieldwp_out}, i);
            check("bulk_data", {26'd0, field_out}, i);
            check("bulk_buf", {29'd0, bufp_out}, 5);
            if (i == SIZE - 2) check("bulk_busy_before_last", {31'd0, load_busy}, 1);
        end
        check("bulk_done_with_last", {31'd0, load_done}, 1);
        check("bulk_busy_fell", {31'd0, load_busy}, 0);
        host_valid = 1'b0;
        cycle();
        check("bulk_strobes", n_str, SIZE);
        check("bulk_done_count", n_done, 1);

        // Contention at host field 10.
        start_load(0);
        feed(10, 0);
        host_valid = 1'b1; host_data = W'(10);
        core_req = 1'b1; core_buf = 3'd2; core_field = 5'd7; core_data = 6'h2A;
        cycle();
        check("cont_core_buf", {29'd0, bufp_out}, 2);
        check("cont_core_field", {27'd0, fieldwp_out}, 7);
        check("cont_core_data", {26'd0, field_out}, 32'h2A);
        core_req = 1'b0;
        cycle();
        check("cont_host_resume", {27'd0, fieldwp_out}, 10);
        check("cont_host_buf", {29'd0, bufp_out}, 0);
        feed(SIZE - 11, 11);
        cycle();

        // Out-of-range core write.
        n_str = 0;
        core_req = 1'b1; core_buf = 3'd1; core_field = 5'd22; core_data = 6'h3F;
        cycle();
        check("oor_no_strobe", n_str, 0);
        check("oor_err_pulse", {31'd0, core_err}, 1);
        core_req = 1'b0;
        cycle();
        check("oor_err_cleared", {31'd0, core_err}, 0);

        // Reset in the middle of a load at fcnt=13.
        start_load(4);
        feed(13, 0);
        n_str = 0; n_done = 0;
        reset = 1'b1; host_valid = 1'b1; host_data = W'(13);
        cycle();
        cycle();
        check("rst_mid_no_strobe", n_str, 0);
        check("rst_mid_no_done", n_done, 0);
        set_idle();
        cycle();
        start_load(6);
        feed(1, 40);
        check("rst_restart_field", {27'd0, fieldwp_out}, 0);
        check("rst_restart_buf", {29'd0, bufp_out}, 6);
        feed(SIZE - 1, 41);
        cycle();

        // host_start during a load of buffer 1 is ignored.
        n_str = 0; n_b3 = 0;
        start_load(1);
        feed(5, 0);
        host_start = 1'b1; host_buf = 3'd3; host_valid = 1'b1; host_data = W'(5);
        cycle();
        host_start = 1'b0;
        feed(SIZE - 6, 6);
        check("ignore_start_no_buf3", n_b3, 0);
        check("ignore_start_strobes", n_str, SIZE);
        cycle();

        // Back-to-back loads: second start issued while load_done is visible.
        n_str = 0; n_done = 0;
        start_load(7);
        feed(SIZE, 20);
        check("b2b_first_done", {31'd0, load_done}, 1);
        start_load(2);
        feed(1, 0);
        check("b2b_second_starts_at_0", {27'd0, fieldwp_out}, 0);
        feed(SIZE - 1, 1);
        cycle();
        check("b2b_strobes", n_str, 2 * SIZE);
        check("b2b_done_count", n_done, 2);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            host_start = ($urandom_range(0, 15) == 0);
            host_buf   = 3'($urandom_range(0, 7));
            host_valid = ($urandom_range(0, 3) != 0);
            host_data  = W'($urandom);
            core_req   = ($urandom_range(0, 3) == 0);
            core_buf   = 3'($urandom_range(0, 7));
            core_field = 5'($urandom_range(0, 31));
            core_data  = W'($urandom);
            cycle();
        end
        set_idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
